// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the Uart8 receiver, the rx FIFO and its consumer.
// Optional macro UART_RX_FIFO_ERR_TAG_EN adds the outErr head-entry tag.
interface uart_rx_fifo_if;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxByte;
  logic       outValid;
  logic       outReady;
  logic [7:0] outByte;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  logic       outErr;

  modport master (
    output rxDone, rxErr, rxByte, outReady,
    input  outValid, outByte, outErr
  );
  modport slave (
    input  rxDone, rxErr, rxByte, outReady,
    output outValid, outByte, outErr
  );
`else
  modport master (
    output rxDone, rxErr, rxByte, outReady,
    input  outValid, outByte
  );
  modport slave (
    input  rxDone, rxErr, rxByte, outReady,
    output outValid, outByte
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the Uart8 receiver. Each rising edge of rxDone
// pushes one frame; the consumer sees a first-word-fall-through valid/ready
// port. A push into a full FIFO without a same-cycle pop sets sticky overflow.
// Optional macro UART_RX_FIFO_ERR_TAG_EN: store {err,byte} and expose outErr;
// without it, errored frames are silently dropped.
module uart_rx_fifo #(
  parameter int unsigned  DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstN,
  uart_rx_fifo_if.slave   rx,
  input  logic            clrOverflow,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            overflow
);

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int unsigned DATA_W = 9;
`else
  localparam int unsigned DATA_W = 8;
`endif
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              rx_done_prev_q;
  logic              push_edge, push_req, pop, wr_en, ovf_set;
  logic              not_empty, is_full;
  logic [DATA_W-1:0] wr_data, head;

  assign push_edge = rx.rxDone & ~rx_done_prev_q;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign push_req  = push_edge;
  assign wr_data   = {rx.rxErr, rx.rxByte};
`else
  // Errored frames never reach storage and cannot cause overflow.
  assign push_req  = push_edge & ~rx.rxErr;
  assign wr_data   = rx.rxByte;
`endif

  assign not_empty = (count_q != '0);
  assign is_full   = (count_q == DEPTH_CNT);
  assign pop       = not_empty & rx.outReady;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign wr_en     = push_req & (~is_full | pop);
  assign ovf_set   = push_req & is_full & ~pop;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    // Set wins over clear.
    if (ovf_set)          overflow_d = 1'b1;
    else if (clrOverflow) overflow_d = 1'b0;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      rx_done_prev_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      rx_done_prev_q <= rx.rxDone;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign head        = mem[rd_ptr_q];
  assign rx.outValid = not_empty;
  // Gate with not_empty so an empty FIFO always shows zero, never stale data.
  assign rx.outByte  = not_empty ? head[7:0] : 8'h00;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign rx.outErr   = not_empty & head[8];
`endif

  assign count    = count_q;
  assign full     = is_full;
  assign overflow = overflow_q;

endmodule
